// File: rtl/obi_instr_data_arbiter.sv
// obi_instr_data_arbiter
// Shares one single-ported OBI memory port between an instruction fetch port
// and a data/LSU port. A selection is held stable until granted, accepted
// transactions are tagged in a small in-order FIFO, and each mem_rvalid_i is
// routed back to the requester found at the FIFO head.
//
// Optional build macro OBI_ARB_RR_EN: round-robin selection on contention in
// IDLE. Without it, data has fixed priority over instr.
//
// Handshakes: a request transfers in the cycle where mem_req_o & mem_gnt_i are
// both high; once mem_req_o is raised its selection (address, we, be, wdata)
// stays frozen until that grant. Responses carry no ready: mem_rvalid_i is
// accepted unconditionally and forwarded combinationally in the same cycle.
module obi_instr_data_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [CW-1:0]           outstanding_o,
    output logic                    err_o,
    output logic                    arb_state_o
);

    localparam int  PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                     state_q;
    logic                       sel_q;
    logic                       sel;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       head;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       err_q;
`ifdef OBI_ARB_RR_EN
    logic                       rr_last_q;
`endif

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = tag_q[rd_ptr_q];

    // Source selection: frozen while LOCKED, otherwise priority or round-robin.
    always_comb begin
        sel = SEL_INSTR;
        if (state_q == LOCKED) begin
            sel = sel_q;
        end else begin
`ifdef OBI_ARB_RR_EN
            if (data_req_i && instr_req_i) sel = ~rr_last_q;
            else if (data_req_i)           sel = SEL_DATA;
            else                           sel = SEL_INSTR;
`else
            sel = data_req_i ? SEL_DATA : SEL_INSTR;
`endif
        end
    end

    // Request/grant/response muxing; instr fetches are full-word reads.
    always_comb begin
        mem_req_o   = ((sel == SEL_DATA) ? data_req_i : instr_req_i) & ~full;
        mem_addr_o  = (sel == SEL_DATA) ? data_addr_i : instr_addr_i;
        mem_we_o    = (sel == SEL_DATA) ? data_we_i : 1'b0;
        mem_be_o    = (sel == SEL_DATA) ? data_be_i : '1;
        mem_wdata_o = (sel == SEL_DATA) ? data_wdata_i : '0;
        push        = mem_req_o & mem_gnt_i;
        pop         = mem_rvalid_i & ~empty;
        instr_gnt_o = push & (sel == SEL_INSTR);
        data_gnt_o  = push & (sel == SEL_DATA);
        instr_rvalid_o = pop & (head == SEL_INSTR);
        data_rvalid_o  = pop & (head == SEL_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
    end

    // Arbiter FSM: lock the selection when a request is left ungranted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= SEL_INSTR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q <= LOCKED;
                        sel_q   <= sel;
                    end
                end
                LOCKED: begin
                    if (push) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OBI_ARB_RR_EN
    // Remember the last granted source for round-robin fairness.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rr_last_q <= SEL_INSTR;
        else if (push) rr_last_q <= sel;
    end
`endif

    // Response-tag FIFO, occupancy counter and sticky spurious-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (mem_rvalid_i && empty) err_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign arb_state_o   = state_q;

endmodule

// File: tb/tb_obi_instr_data_arbiter.sv
// tb_obi_instr_data_arbiter
// Directed vector table for obi_instr_data_arbiter (MAX_OUTSTANDING=2) plus
// hand sequences for contention streams and reset behaviour.
// Honours OBI_ARB_RR_EN when the design is built with it.
module tb_obi_instr_data_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic        instr_gnt;
  logic [31:0] instr_addr = '0;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0;
  logic        data_gnt;
  logic [31:0] data_addr = '0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_wdata = '0;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  outstanding;
  logic        err;
  logic        arb_state;

  int checks = 0;
  int errors = 0;

  obi_instr_data_arbiter #(
    .MAX_OUTSTANDING(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
    .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err), .arb_state_o(arb_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic [31:0] da; logic dwe; logic [3:0] dbe; logic [31:0] dwd;
    logic        gnt; logic rv; logic [31:0] rd;
    logic        e_req; logic [31:0] e_addr; logic e_we; logic [3:0] e_be;
    logic        e_ig; logic e_dg; logic e_irv; logic e_drv; logic [1:0] e_out; logic e_err;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic [31:0] da, input logic dwe, input logic [3:0] dbe,
    input logic [31:0] dwd, input logic gnt, input logic rv, input logic [31:0] rd,
    input logic e_req, input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
    input logic e_ig, input logic e_dg, input logic e_irv, input logic e_drv,
    input logic [1:0] e_out, input logic e_err);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dwe = dwe; v.dbe = dbe; v.dwd = dwd;
    v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    instr_req = v.ir; instr_addr = v.ia;
    data_req = v.dr; data_addr = v.da; data_we = v.dwe; data_be = v.dbe; data_wdata = v.dwd;
    mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rd;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = '0; data_req = 0; data_addr = '0; data_we = 0;
    data_be = '0; data_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    //              ir ia       dr da        we be    wd      g rv rd     | req addr     we be    ig dg irv drv out err
    // single fetch
    vecs[0]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    vecs[1]  = mk(1, 32'h180, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h180,  0, 4'hF, 1, 0, 0, 0, 2'd0, 0);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h13, 0, 32'h0,    0, 4'hF, 0, 0, 1, 0, 2'd1, 0);
    vecs[3]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    // contention: data first, then instr; responses in order
    vecs[4]  = mk(1, 32'h200, 1, 32'h1000, 1, 4'h3, 32'hAA, 1, 0, 32'h0,  1, 32'h1000, 1, 4'h3, 0, 1, 0, 0, 2'd0, 0);
    vecs[5]  = mk(1, 32'h200, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h200,  0, 4'hF, 1, 0, 0, 0, 2'd1, 0);
    vecs[6]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h55, 0, 32'h0,    0, 4'hF, 0, 0, 0, 1, 2'd2, 0);
    vecs[7]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h66, 0, 32'h0,    0, 4'hF, 0, 0, 1, 0, 2'd1, 0);
    vecs[8]  = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    // lock: data held ungranted, instr arrives, selection stays on data
    vecs[9]  = mk(0, 32'h0,   1, 32'h1004, 0, 4'hF, 32'h0,  0, 0, 32'h0,  1, 32'h1004, 0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    vecs[10] = mk(1, 32'h300, 1, 32'h1004, 0, 4'hF, 32'h0,  0, 0, 32'h0,  1, 32'h1004, 0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    vecs[11] = mk(1, 32'h300, 1, 32'h1004, 0, 4'hF, 32'h0,  0, 0, 32'h0,  1, 32'h1004, 0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    vecs[12] = mk(1, 32'h300, 1, 32'h1004, 0, 4'hF, 32'h0,  1, 0, 32'h0,  1, 32'h1004, 0, 4'hF, 0, 1, 0, 0, 2'd0, 0);
    vecs[13] = mk(1, 32'h300, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h300,  0, 4'hF, 1, 0, 0, 0, 2'd1, 0);
    vecs[14] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h77, 0, 32'h0,    0, 4'hF, 0, 0, 0, 1, 2'd2, 0);
    vecs[15] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h88, 0, 32'h0,    0, 4'hF, 0, 0, 1, 0, 2'd1, 0);
    vecs[16] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    // full: two fetches outstanding block the third; a pop unblocks one cycle later
    vecs[17] = mk(1, 32'h400, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h400,  0, 4'hF, 1, 0, 0, 0, 2'd0, 0);
    vecs[18] = mk(1, 32'h404, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h404,  0, 4'hF, 1, 0, 0, 0, 2'd1, 0);
    vecs[19] = mk(1, 32'h408, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  0, 32'h408,  0, 4'hF, 0, 0, 0, 0, 2'd2, 0);
    vecs[20] = mk(1, 32'h408, 0, 32'h0,    0, 4'h0, 32'h0,  1, 1, 32'h1,  0, 32'h408,  0, 4'hF, 0, 0, 1, 0, 2'd2, 0);
    vecs[21] = mk(1, 32'h408, 0, 32'h0,    0, 4'h0, 32'h0,  1, 0, 32'h0,  1, 32'h408,  0, 4'hF, 1, 0, 0, 0, 2'd1, 0);
    vecs[22] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h2,  0, 32'h0,    0, 4'hF, 0, 0, 1, 0, 2'd2, 0);
    vecs[23] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h3,  0, 32'h0,    0, 4'hF, 0, 0, 1, 0, 2'd1, 0);
    vecs[24] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    // spurious response: not forwarded, sticky err
    vecs[25] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 1, 32'h99, 0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 0);
    vecs[26] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 1);
    vecs[27] = mk(0, 32'h0,   0, 32'h0,    0, 4'h0, 32'h0,  0, 0, 32'h0,  0, 32'h0,    0, 4'hF, 0, 0, 0, 0, 2'd0, 1);

    // reset state
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #2;
    check("reset mem_req", mem_req, 0);
    check("reset instr_gnt", instr_gnt, 0);
    check("reset data_gnt", data_gnt, 0);
    check("reset instr_rvalid", instr_rvalid, 0);
    check("reset data_rvalid", data_rvalid, 0);
    check("reset outstanding", outstanding, 0);
    check("reset err", err, 0);
    check("reset state", arb_state, 0);
    @(negedge clk);
    rst = 0;

    // vector table
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_req);
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      check($sformatf("v%0d mem_be", i), mem_be, vecs[i].e_be);
      check($sformatf("v%0d instr_gnt", i), instr_gnt, vecs[i].e_ig);
      check($sformatf("v%0d data_gnt", i), data_gnt, vecs[i].e_dg);
      check($sformatf("v%0d instr_rvalid", i), instr_rvalid, vecs[i].e_irv);
      check($sformatf("v%0d data_rvalid", i), data_rvalid, vecs[i].e_drv);
      check($sformatf("v%0d outstanding", i), outstanding, vecs[i].e_out);
      check($sformatf("v%0d err", i), err, vecs[i].e_err);
      if (vecs[i].e_irv) check($sformatf("v%0d instr_rdata", i), instr_rdata, vecs[i].rd);
      if (vecs[i].e_drv) check($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].rd);
      if (vecs[i].e_dg)  check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].dwd);
    end

    // reset pulse clears sticky err
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #2;
    check("rst pulse err", err, 0);
    @(negedge clk);
    rst = 0;

    // continuous contention with immediate responses
    for (int k = 0; k < 4; k++) begin
      logic exp_data;
`ifdef OBI_ARB_RR_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      @(negedge clk);
      instr_req = 1; instr_addr = 32'h600; data_req = 1; data_addr = 32'h2000;
      data_we = 0; data_be = 4'hF; mem_gnt = 1; mem_rvalid = (k > 0); mem_rdata = 32'h5;
      #2;
      check($sformatf("stream%0d data_gnt", k), data_gnt, exp_data);
      check($sformatf("stream%0d instr_gnt", k), instr_gnt, !exp_data);
      check($sformatf("stream%0d mem_addr", k), mem_addr, exp_data ? 32'h2000 : 32'h600);
      check($sformatf("stream%0d outstanding", k), outstanding, (k > 0) ? 1 : 0);
    end
    @(negedge clk);
    idle_inputs();
    mem_rvalid = 1;
    #2;
    check("stream drain rvalid", instr_rvalid | data_rvalid, 1);
    check("stream drain err", err, 0);

    // reset with a transaction outstanding, then a late response
    @(negedge clk);
    idle_inputs();
    instr_req = 1; instr_addr = 32'h500; mem_gnt = 1;
    #2;
    check("midrst gnt", instr_gnt, 1);
    @(negedge clk);
    idle_inputs();
    check("midrst outstanding before", outstanding, 1);
    rst = 1;
    #2;
    check("midrst outstanding", outstanding, 0);
    @(negedge clk);
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    #2;
    check("late rvalid instr", instr_rvalid, 0);
    check("late rvalid data", data_rvalid, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    check("late rvalid err", err, 1);
    check("late rvalid outstanding", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
